// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and writeback entry type for the register-file write side
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match search over pending writeback entries
// Entries are ordered oldest (index 0) to youngest (index N-1); the last hit wins.
module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 32
) (
    input  logic [REG_ADDR_W-1:0]        addr_i,
    input  logic [N-1:0]                 valid_i,
    input  logic [N-1:0][REG_ADDR_W-1:0] rd_i,
    input  logic [N-1:0][W-1:0]          data_i,
    output logic                         hit_o,
    output logic [W-1:0]                 data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            if ((addr_i != '0) && valid_i[i] && (rd_i[i] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[i];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - writeback FIFO driving the register-file write port with read-side forwarding
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = cpu_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  wb_stall,
    output logic                  WB,
    output logic [REG_ADDR_W-1:0] rd_address,
    output logic [XLEN-1:0]       write_data,
    input  logic [REG_ADDR_W-1:0] rs1_address,
    input  logic [REG_ADDR_W-1:0] rs2_address,
    output logic                  rs1_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs2_fwd_data,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NSRC  = DEPTH + 1;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  wb_q, wb_d;
    logic [REG_ADDR_W-1:0] rd_address_q, rd_address_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;
    wb_entry_t             mem_q [DEPTH];

    logic push, pop;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    // Writes to x0 complete the handshake but are never stored.
    assign push     = in_valid && in_ready && (in_rd != '0);
    assign pop      = (count_q != '0) && !wb_stall;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wb_d         = 1'b0;
        rd_address_d = rd_address_q;
        write_data_d = write_data_q;
        if (pop) begin
            wb_d         = 1'b1;
            rd_address_d = mem_q[rd_ptr_q].rd;
            write_data_d = mem_q[rd_ptr_q].data;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wb_q         <= 1'b0;
            rd_address_q <= '0;
            write_data_q <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wb_q         <= wb_d;
            rd_address_q <= rd_address_d;
            write_data_q <= write_data_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: in_rd, data: in_data};
        end
    end

    assign WB         = wb_q;
    assign rd_address = rd_address_q;
    assign write_data = write_data_q;
    assign empty      = (count_q == '0) && !wb_q;

    // Source 0 is the in-flight write; sources 1..DEPTH are FIFO slots oldest to youngest.
    logic [NSRC-1:0]                 src_valid;
    logic [NSRC-1:0][REG_ADDR_W-1:0] src_rd;
    logic [NSRC-1:0][XLEN-1:0]       src_data;
    logic [PTR_W-1:0]                idx;

    always_comb begin
        idx          = '0;
        src_valid[0] = wb_q;
        src_rd[0]    = rd_address_q;
        src_data[0]  = write_data_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx              = rd_ptr_q + PTR_W'(k);
            src_valid[k + 1] = (CNT_W'(k) < count_q);
            src_rd[k + 1]    = mem_q[idx].rd;
            src_data[k + 1]  = mem_q[idx].data;
        end
    end

    wb_fwd_match #(.N(NSRC), .W(XLEN)) u_fwd_rs1 (
        .addr_i  (rs1_address),
        .valid_i (src_valid),
        .rd_i    (src_rd),
        .data_i  (src_data),
        .hit_o   (rs1_fwd_valid),
        .data_o  (rs1_fwd_data)
    );

    wb_fwd_match #(.N(NSRC), .W(XLEN)) u_fwd_rs2 (
        .addr_i  (rs2_address),
        .valid_i (src_valid),
        .rd_i    (src_rd),
        .data_i  (src_data),
        .hit_o   (rs2_fwd_valid),
        .data_o  (rs2_fwd_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue against a queue-based model
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        wb_stall = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  rs1_address = '0;
    logic [4:0]  rs2_address = '0;
    logic        in_ready, WB, rs1_fwd_valid, rs2_fwd_valid, empty;
    logic [4:0]  rd_address;
    logic [31:0] write_data, rs1_fwd_data, rs2_fwd_data;

    wb_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .wb_stall(wb_stall),
        .WB(WB), .rd_address(rd_address), .write_data(write_data),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          mwb;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    bit          last_acc;
    bit          cmp_en;
    int          total, passed;
    logic [4:0]  log_rd [0:255];
    logic [31:0] log_data [0:255];
    int          wcount;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mwb   = 1'b0;
        mrd   = '0;
        mdata = '0;
    endtask

    function automatic void model_fwd(input logic [4:0] a, output bit v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0 && !v; i--) begin
                if (mq[i].rd == a) begin
                    v = 1'b1;
                    d = mq[i].data;
                end
            end
            if (!v && mwb && mrd == a) begin
                v = 1'b1;
                d = mdata;
            end
        end
    endfunction

    // One clock edge: advance the model with the inputs held across the edge.
    task automatic step();
        bit ready;
        @(posedge clk);
        ready = (mq.size() < DEPTH);
        if (!wb_stall && mq.size() > 0) begin
            mwb   = 1'b1;
            mrd   = mq[0].rd;
            mdata = mq[0].data;
            void'(mq.pop_front());
        end else begin
            mwb = 1'b0;
        end
        if (in_valid && ready && in_rd != 5'd0) mq.push_back('{in_rd, in_data});
        last_acc = in_valid && ready;
        #1;
    endtask

    task automatic compare();
        bit          v1, v2;
        logic [31:0] d1, d2;
        model_fwd(rs1_address, v1, d1);
        model_fwd(rs2_address, v2, d2);
        chk("in_ready",      in_ready,      (mq.size() < DEPTH));
        chk("empty",         empty,         (mq.size() == 0) && !mwb);
        chk("WB",            WB,            mwb);
        chk("rd_address",    rd_address,    mrd);
        chk("write_data",    write_data,    mdata);
        chk("rs1_fwd_valid", rs1_fwd_valid, v1);
        chk("rs1_fwd_data",  rs1_fwd_data,  d1);
        chk("rs2_fwd_valid", rs2_fwd_valid, v2);
        chk("rs2_fwd_data",  rs2_fwd_data,  d2);
    endtask

    initial begin
        int mark, acc, cyc;
        fork
            forever begin
                @(negedge clk);
                if (rst_n && cmp_en) begin
                    compare();
                    if (WB) begin
                        log_rd[wcount[7:0]]   = rd_address;
                        log_data[wcount[7:0]] = write_data;
                        wcount++;
                    end
                end
            end
        join_none

        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_WB", WB, 0);
        chk("reset_empty", empty, 1);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_rd_address", rd_address, 0);
        chk("reset_write_data", write_data, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // single push latency
        in_valid = 1; in_rd = 5; in_data = 32'hDEADBEEF;
        step();
        in_valid = 0;
        chk("single_n_WB", WB, 0);
        step();
        chk("single_n1_WB", WB, 1);
        chk("single_n1_rd", rd_address, 5);
        chk("single_n1_data", write_data, 32'hDEADBEEF);
        step();
        chk("single_n2_WB", WB, 0);
        chk("single_n2_empty", empty, 1);

        // fill, reject on full even while popping
        mark = wcount;
        wb_stall = 1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_rd = 5'(i); in_data = 32'h100 + i;
            step();
        end
        chk("fill_full_in_ready", in_ready, 0);
        in_rd = 6; in_data = 32'h600; wb_stall = 0;
        step();
        chk("fill_reject_acc", last_acc, 0);
        in_valid = 0;
        repeat (6) step();
        chk("fill_drain_count", wcount - mark, 4);
        for (int j = 0; j < 4; j++) begin
            chk("fill_order_rd", log_rd[(mark + j) % 256], j + 1);
            chk("fill_order_data", log_data[(mark + j) % 256], 32'h101 + j);
        end

        // forwarding youngest match
        wb_stall = 1;
        in_valid = 1; in_rd = 7; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_valid = 0;
        rs1_address = 7; rs2_address = 0;
        #1;
        chk("fwd_rs1_valid", rs1_fwd_valid, 1);
        chk("fwd_rs1_data", rs1_fwd_data, 32'h22);
        chk("fwd_rs2_valid", rs2_fwd_valid, 0);
        chk("fwd_rs2_data", rs2_fwd_data, 0);
        wb_stall = 0;
        step();
        chk("fwd_pop1_data", rs1_fwd_data, 32'h22);
        step();
        chk("fwd_wbreg_valid", rs1_fwd_valid, 1);
        chk("fwd_wbreg_data", rs1_fwd_data, 32'h22);
        step();
        chk("fwd_done_valid", rs1_fwd_valid, 0);
        rs1_address = 0;

        // x0 write dropped
        mark = wcount;
        in_valid = 1; in_rd = 0; in_data = 32'hFFFF;
        step();
        in_valid = 0;
        chk("rd0_acc", last_acc, 1);
        chk("rd0_empty", empty, 1);
        repeat (3) step();
        chk("rd0_no_wb", wcount - mark, 0);

        // streaming, then random stalls, same sequence
        for (int pass = 0; pass < 2; pass++) begin
            mark = wcount; acc = 0; cyc = 0;
            while (acc < 20 && cyc < 400) begin
                in_valid = 1;
                in_rd    = 5'((acc % 31) + 1);
                in_data  = 32'hA000_0000 + 32'(acc * 7);
                wb_stall = (pass == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                rs1_address = 5'($urandom_range(0, 31));
                rs2_address = 5'($urandom_range(0, 31));
                step();
                if (last_acc) acc++;
                cyc++;
            end
            in_valid = 0; wb_stall = 0;
            repeat (8) step();
            chk("stream_accepted", acc, 20);
            chk("stream_wb_count", wcount - mark, 20);
            for (int j = 0; j < 20; j++) begin
                chk("stream_rd", log_rd[(mark + j) % 256], (j % 31) + 1);
                chk("stream_data", log_data[(mark + j) % 256], 32'hA000_0000 + 32'(j * 7));
            end
        end
        rs1_address = 0; rs2_address = 0;

        // asynchronous reset mid-drain
        wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_rd = 5'(9 + i); in_data = 32'h900 + i;
            step();
        end
        in_valid = 0; wb_stall = 0;
        step();
        chk("rstmid_pre_WB", WB, 1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rstmid_WB", WB, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        step();
        chk("rstmid_after_WB", WB, 0);
        chk("rstmid_after_empty", empty, 1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
